pmem_arbiter: RTL and testbench

//   Shares the single combinational PMEM port (DPI pmem_read/pmem_write) between IFU (read-only) and LSU (read/write).

---
 rtl/pmem_arbiter_if.sv | 46 ++++
 rtl/pmem_arbiter.sv | 130 +++++++++++++
 tb/tb_pmem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Bundles the IFU/LSU request/response channels and the PMEM port seen by pmem_arbiter.
// slave: the arbiter side; master: requesters plus the PMEM model driving the other ends.
interface pmem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_rdata;

  logic        mem_valid;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one combinational PMEM port between IFU and LSU, one transaction in flight at a time.
// Define PMEM_ARB_RR_EN for round-robin grant; otherwise LSU has fixed priority.
module pmem_arbiter #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input logic        clk,
  input logic        rst,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam int              LAT_M1   = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_INIT = LAT_M1[CNT_W-1:0];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic [31:0]      addr_q;
  logic             wen_q;
  logic [31:0]      wdata_q;
  logic [7:0]       wmask_q;
  logic [31:0]      ifu_rdata_q;
  logic [31:0]      lsu_rdata_q;
  logic             mem_valid_q;
  logic             ifu_resp_q;
  logic             lsu_resp_q;

  logic             accept_ok;
  logic             grant_lsu;
  logic             grant_ifu;
  logic             fire;
  logic             resp_taken;

`ifdef PMEM_ARB_RR_EN
  // last_grant: 1 = LSU was granted last, so IFU wins the next tie
  logic last_grant;
  assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_grant);
`else
  assign grant_lsu = bus.lsu_req_valid;
`endif
  assign grant_ifu = bus.ifu_req_valid && !grant_lsu;

  // Ready is gated by rst so nothing looks accepted while reset overrides the fire
  assign accept_ok         = (state == IDLE) && !rst;
  assign bus.lsu_req_ready = accept_ok && grant_lsu;
  assign bus.ifu_req_ready = accept_ok && grant_ifu;
  assign fire              = bus.lsu_req_ready || bus.ifu_req_ready;
  assign resp_taken        = owner ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
`ifdef PMEM_ARB_RR_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            owner   <= grant_lsu;
            addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q   <= grant_lsu && bus.lsu_wen;
            wdata_q <= grant_lsu ? bus.lsu_wdata : 32'h0;
            wmask_q <= grant_lsu ? bus.lsu_wmask : 8'h0;
            cnt     <= CNT_INIT;
`ifdef PMEM_ARB_RR_EN
            last_grant <= grant_lsu;
`endif
            if (LATENCY == 0) begin
              state       <= ACCESS;
              mem_valid_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= ACCESS;
            mem_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACCESS: begin
          // Sampled in the single PMEM cycle; for stores this is the pre-write word
          if (owner) lsu_rdata_q <= bus.mem_rdata;
          else       ifu_rdata_q <= bus.mem_rdata;
          mem_valid_q <= 1'b0;
          lsu_resp_q  <= owner;
          ifu_resp_q  <= !owner;
          state       <= RESP;
        end
        RESP: begin
          if (resp_taken) begin
            lsu_resp_q <= 1'b0;
            ifu_resp_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ifu_resp_valid = ifu_resp_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_resp_valid = lsu_resp_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_wen        = mem_valid_q && wen_q;
  assign bus.mem_raddr      = addr_q;
  assign bus.mem_waddr      = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: three instances with LATENCY 1, 3 and 0, each on its own PMEM model.
// Build with +define+PMEM_ARB_RR_EN to expect round-robin grants.
module tb_pmem_arbiter;
  logic clk = 1'b0;
  logic rst1, rst3, rst0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wen_cnt1 = 0;
  int   wen_cnt3 = 0;
  int   dbl_valid = 0;
  logic prev_v1 = 1'b0, prev_v3 = 1'b0, prev_v0 = 1'b0;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] mem0 [256];

  pmem_arbiter_if bus1 ();
  pmem_arbiter_if bus3 ();
  pmem_arbiter_if bus0 ();

  pmem_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
  pmem_arbiter #(.LATENCY(3), .CNT_W(4)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));
  pmem_arbiter #(.LATENCY(0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));

  always #5 clk = ~clk;

  assign bus1.mem_rdata = mem1[bus1.mem_raddr[9:2]];
  assign bus3.mem_rdata = mem3[bus3.mem_raddr[9:2]];
  assign bus0.mem_rdata = mem0[bus0.mem_raddr[9:2]];

  // PMEM models: byte-masked writes, write counters and back-to-back mem_valid detection
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus1.mem_valid && bus1.mem_wen) begin
      for (int j = 0; j < 4; j++)
        if (bus1.mem_wmask[j]) mem1[bus1.mem_waddr[9:2]][8*j +: 8] <= bus1.mem_wdata[8*j +: 8];
      wen_cnt1 <= wen_cnt1 + 1;
    end
    if (bus3.mem_valid && bus3.mem_wen) begin
      for (int j = 0; j < 4; j++)
        if (bus3.mem_wmask[j]) mem3[bus3.mem_waddr[9:2]][8*j +: 8] <= bus3.mem_wdata[8*j +: 8];
      wen_cnt3 <= wen_cnt3 + 1;
    end
    if ((bus1.mem_valid && prev_v1) || (bus3.mem_valid && prev_v3) || (bus0.mem_valid && prev_v0))
      dbl_valid <= dbl_valid + 1;
    prev_v1 <= bus1.mem_valid;
    prev_v3 <= bus3.mem_valid;
    prev_v0 <= bus0.mem_valid;
  end

  task automatic ifu_read1(input logic [31:0] a, output logic [31:0] d, output bit ok);
    int n;
    ok = 1'b1;
    d  = '0;
    @(negedge clk);
    bus1.ifu_req_valid = 1'b1;
    bus1.ifu_addr      = a;
    #1;
    n = 0;
    while (!bus1.ifu_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.ifu_req_valid = 1'b0;
    #1;
    n = 0;
    while (!bus1.ifu_resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    d = bus1.ifu_rdata;
    bus1.ifu_resp_ready = 1'b1;
    @(negedge clk);
    bus1.ifu_resp_ready = 1'b0;
  endtask

  task automatic lsu_op1(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [7:0] wm, output logic [31:0] d, output bit ok);
    int n;
    ok = 1'b1;
    d  = '0;
    @(negedge clk);
    bus1.lsu_req_valid = 1'b1;
    bus1.lsu_addr      = a;
    bus1.lsu_wen       = w;
    bus1.lsu_wdata     = wd;
    bus1.lsu_wmask     = wm;
    #1;
    n = 0;
    while (!bus1.lsu_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.lsu_req_valid = 1'b0;
    bus1.lsu_wen       = 1'b0;
    #1;
    n = 0;
    while (!bus1.lsu_resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    d = bus1.lsu_rdata;
    bus1.lsu_resp_ready = 1'b1;
    @(negedge clk);
    bus1.lsu_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
    bus1.ifu_req_valid = 1'b1;
    bus1.lsu_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus1.ifu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ifu_ready got %b want 0", bus1.ifu_req_ready); end
    checks++; if (bus1.lsu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_lsu_ready got %b want 0", bus1.lsu_req_ready); end
    checks++; if (bus1.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_valid got %b want 0", bus1.mem_valid); end
    checks++; if (bus1.mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_wen got %b want 0", bus1.mem_wen); end
    checks++; if ({bus1.ifu_resp_valid, bus1.lsu_resp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rst_resp_valid got %b want 00", {bus1.ifu_resp_valid, bus1.lsu_resp_valid}); end
    checks++; if (bus1.mem_raddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_raddr got %h want 0", bus1.mem_raddr); end
    checks++; if (bus1.ifu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_ifu_rdata got %h want 0", bus1.ifu_rdata); end
    bus1.ifu_req_valid = 1'b0;
    bus1.lsu_req_valid = 1'b0;
    rst1 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;
  endtask

  task automatic test_ifu_read();
    mem1[0] <= 32'h00000413;
    @(negedge clk);
    bus1.ifu_req_valid = 1'b1;
    bus1.ifu_addr      = 32'h80000000;
    #1;
    checks++; if (bus1.ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL ifu_ready got %b want 1", bus1.ifu_req_ready); end
    checks++; if (bus1.lsu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL ifu_lsu_ready got %b want 0", bus1.lsu_req_ready); end
    @(posedge clk);
    @(negedge clk);
    bus1.ifu_req_valid = 1'b0;
    #1;
    checks++; if (bus1.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL ifu_mem_valid_t1 got %b want 0", bus1.mem_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus1.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL ifu_mem_valid_t2 got %b want 1", bus1.mem_valid); end
    checks++; if (bus1.mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL ifu_mem_wen got %b want 0", bus1.mem_wen); end
    checks++; if (bus1.mem_raddr !== 32'h80000000) begin errors++; $display("[TB] FAIL ifu_mem_raddr got %h want 80000000", bus1.mem_raddr); end
    @(negedge clk);
    #1;
    checks++; if (bus1.ifu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ifu_resp_valid_t3 got %b want 1", bus1.ifu_resp_valid); end
    checks++; if (bus1.ifu_rdata !== 32'h00000413) begin errors++; $display("[TB] FAIL ifu_rdata got %h want 00000413", bus1.ifu_rdata); end
    checks++; if (bus1.lsu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ifu_lsu_resp got %b want 0", bus1.lsu_resp_valid); end
    checks++; if (bus1.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL ifu_mem_valid_t3 got %b want 0", bus1.mem_valid); end
    bus1.ifu_resp_ready = 1'b1;
    @(negedge clk);
    bus1.ifu_resp_ready = 1'b0;
    #1;
    checks++; if (bus1.ifu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ifu_resp_drop got %b want 0", bus1.ifu_resp_valid); end
  endtask

  task automatic test_lsu_store();
    logic [31:0] d;
    bit          ok;
    int          base;
    mem1[64] <= 32'h11223344;
    mem1[65] <= 32'hAAAAAAAA;
    base = wen_cnt1;
    lsu_op1(32'h80000100, 1'b1, 32'hDEADBEEF, 8'h0F, d, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL store_timeout got %b want 1", ok); end
    checks++; if (wen_cnt1 - base !== 1) begin errors++; $display("[TB] FAIL store_wen_count got %0d want 1", wen_cnt1 - base); end
    checks++; if (d !== 32'h11223344) begin errors++; $display("[TB] FAIL store_prewrite got %h want 11223344", d); end
    checks++; if (mem1[64] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL store_word got %h want deadbeef", mem1[64]); end
    ifu_read1(32'h80000100, d, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL readback_timeout got %b want 1", ok); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL readback got %h want deadbeef", d); end
    lsu_op1(32'h80000104, 1'b1, 32'h12345678, 8'h03, d, ok);
    checks++; if (mem1[65] !== 32'hAAAA5678) begin errors++; $display("[TB] FAIL masked_store got %h want aaaa5678", mem1[65]); end
    checks++; if (wen_cnt1 - base !== 2) begin errors++; $display("[TB] FAIL masked_wen_count got %0d want 2", wen_cnt1 - base); end
  endtask

  task automatic test_priority();
    int   n;
    logic exp;
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    bus1.ifu_req_valid = 1'b1;
    bus1.ifu_addr      = 32'h80000000;
    bus1.lsu_req_valid = 1'b1;
    bus1.lsu_addr      = 32'h80000100;
    bus1.lsu_wen       = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef PMEM_ARB_RR_EN
      exp = (k % 2 == 0);
`else
      exp = 1'b1;
`endif
      n = 0;
      while (!(bus1.ifu_req_ready || bus1.lsu_req_ready) && n < 20) begin @(negedge clk); #1; n++; end
      checks++; if (bus1.lsu_req_ready !== exp) begin errors++; $display("[TB] FAIL grant_lsu[%0d] got %b want %b", k, bus1.lsu_req_ready, exp); end
      checks++; if (bus1.ifu_req_ready !== !exp) begin errors++; $display("[TB] FAIL grant_ifu[%0d] got %b want %b", k, bus1.ifu_req_ready, !exp); end
      @(posedge clk);
      @(negedge clk);
      #1;
      n = 0;
      while (!(bus1.ifu_resp_valid || bus1.lsu_resp_valid) && n < 20) begin @(negedge clk); #1; n++; end
      checks++; if (bus1.lsu_resp_valid !== exp) begin errors++; $display("[TB] FAIL owner_resp[%0d] got %b want %b", k, bus1.lsu_resp_valid, exp); end
      checks++; if ((exp ? bus1.lsu_rdata : bus1.ifu_rdata) !== (exp ? 32'hDEADBEEF : 32'h00000413)) begin
        errors++; $display("[TB] FAIL prio_rdata[%0d] got %h want %h", k, exp ? bus1.lsu_rdata : bus1.ifu_rdata, exp ? 32'hDEADBEEF : 32'h00000413);
      end
      bus1.ifu_resp_ready = 1'b1;
      bus1.lsu_resp_ready = 1'b1;
      @(negedge clk);
      bus1.ifu_resp_ready = 1'b0;
      bus1.lsu_resp_ready = 1'b0;
      #1;
    end
    bus1.ifu_req_valid = 1'b0;
    bus1.lsu_req_valid = 1'b0;
  endtask

  task automatic test_resp_stall();
    int n;
    @(negedge clk);
    bus1.ifu_req_valid = 1'b1;
    bus1.ifu_addr      = 32'h80000000;
    #1;
    n = 0;
    while (!bus1.ifu_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    bus1.ifu_req_valid = 1'b0;
    #1;
    n = 0;
    while (!bus1.ifu_resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    bus1.lsu_req_valid = 1'b1;
    bus1.lsu_addr      = 32'h80000100;
    bus1.lsu_wen       = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus1.ifu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, bus1.ifu_resp_valid); end
      checks++; if (bus1.ifu_rdata !== 32'h00000413) begin errors++; $display("[TB] FAIL stall_rdata[%0d] got %h want 00000413", i, bus1.ifu_rdata); end
      checks++; if (bus1.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_mem_valid[%0d] got %b want 0", i, bus1.mem_valid); end
      checks++; if (bus1.lsu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_lsu_ready[%0d] got %b want 0", i, bus1.lsu_req_ready); end
      @(negedge clk);
      #1;
    end
    bus1.lsu_req_valid  = 1'b0;
    bus1.ifu_resp_ready = 1'b1;
    @(negedge clk);
    bus1.ifu_resp_ready = 1'b0;
    #1;
    checks++; if (bus1.ifu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got %b want 0", bus1.ifu_resp_valid); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    mem3[2] <= 32'hCAFEF00D;
    @(negedge clk);
    bus3.lsu_req_valid = 1'b1;
    bus3.lsu_wen       = 1'b1;
    bus3.lsu_addr      = 32'h80000008;
    bus3.lsu_wdata     = 32'hDEADBEEF;
    bus3.lsu_wmask     = 8'h0F;
    #1;
    checks++; if (bus3.lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rw_store_ready got %b want 1", bus3.lsu_req_ready); end
    @(posedge clk);
    @(negedge clk);
    bus3.lsu_req_valid = 1'b0;
    bus3.lsu_wen       = 1'b0;
    rst3 = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus3.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_mem_valid got %b want 0", bus3.mem_valid); end
    rst3 = 1'b0;
    bus3.ifu_req_valid = 1'b1;
    bus3.ifu_addr      = 32'h80000008;
    #1;
    checks++; if (bus3.ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rw_idle_after_rst got %b want 1", bus3.ifu_req_ready); end
    @(posedge clk);
    @(negedge clk);
    bus3.ifu_req_valid = 1'b0;
    #1;
    n = 0;
    while (!bus3.ifu_resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (bus3.ifu_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rw_readback got %h want cafef00d", bus3.ifu_rdata); end
    bus3.ifu_resp_ready = 1'b1;
    @(negedge clk);
    bus3.ifu_resp_ready = 1'b0;
    checks++; if (wen_cnt3 !== 0) begin errors++; $display("[TB] FAIL rw_wen_count got %0d want 0", wen_cnt3); end
    checks++; if (mem3[2] !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rw_mem_word got %h want cafef00d", mem3[2]); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int fires[$];
    mem0[0] <= 32'h0000ABCD;
    @(negedge clk);
    bus0.ifu_req_valid = 1'b1;
    bus0.ifu_addr      = 32'h80000000;
    #1;
    checks++; if (bus0.ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL l0_ready got %b want 1", bus0.ifu_req_ready); end
    t0 = cyc;
    @(negedge clk);
    #1;
    checks++; if (bus0.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL l0_mem_valid_t1 got %b want 1", bus0.mem_valid); end
    checks++; if (bus0.ifu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL l0_resp_early got %b want 0", bus0.ifu_resp_valid); end
    bus0.ifu_resp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus0.ifu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL l0_resp_t2 got %b want 1", bus0.ifu_resp_valid); end
    checks++; if (bus0.ifu_rdata !== 32'h0000ABCD) begin errors++; $display("[TB] FAIL l0_rdata got %h want 0000abcd", bus0.ifu_rdata); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      if (bus0.ifu_req_ready) fires.push_back(cyc - t0);
    end
    checks++; if (fires.size() !== 3) begin errors++; $display("[TB] FAIL b2b_fire_count got %0d want 3", fires.size()); end
    for (int k = 0; k < fires.size() && k < 3; k++) begin
      checks++; if (fires[k] !== 3 * (k + 1)) begin errors++; $display("[TB] FAIL b2b_fire[%0d] got %0d want %0d", k, fires[k], 3 * (k + 1)); end
    end
    bus0.ifu_req_valid = 1'b0;
    @(negedge clk);
    bus0.ifu_resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (dbl_valid !== 0) begin errors++; $display("[TB] FAIL mem_valid_consecutive got %0d want 0", dbl_valid); end
  endtask

  initial begin
    bus1.ifu_req_valid = 1'b0; bus1.ifu_addr = '0; bus1.ifu_resp_ready = 1'b0;
    bus1.lsu_req_valid = 1'b0; bus1.lsu_addr = '0; bus1.lsu_wen = 1'b0;
    bus1.lsu_wdata = '0; bus1.lsu_wmask = '0; bus1.lsu_resp_ready = 1'b0;
    bus3.ifu_req_valid = 1'b0; bus3.ifu_addr = '0; bus3.ifu_resp_ready = 1'b0;
    bus3.lsu_req_valid = 1'b0; bus3.lsu_addr = '0; bus3.lsu_wen = 1'b0;
    bus3.lsu_wdata = '0; bus3.lsu_wmask = '0; bus3.lsu_resp_ready = 1'b0;
    bus0.ifu_req_valid = 1'b0; bus0.ifu_addr = '0; bus0.ifu_resp_ready = 1'b0;
    bus0.lsu_req_valid = 1'b0; bus0.lsu_addr = '0; bus0.lsu_wen = 1'b0;
    bus0.lsu_wdata = '0; bus0.lsu_wmask = '0; bus0.lsu_resp_ready = 1'b0;
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_priority();
    test_resp_stall();
    test_reset_in_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
